div_iter: RTL and testbench

Multi-cycle radix-2 restoring divider for the HI/LO unit. It serves DIV/DIVU and is the division counterpart of the iterative multiplier. It uses the same valid/done single-pulse handshake and the same flag_unsigned convention, so the execute stage drives both units identically. It sits beside the multiplier in EX and stalls the pipeline from accept until done.

---
 rtl/div_iter_if.sv | 25 ++
 rtl/div_iter.sv | 163 ++++++++++++++++
 tb/tb_div_iter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// Handshake and data bundle between the execute stage and the iterative divider.
// The master side (execute stage) drives operands, start and flush. The slave
// side (the divider) returns busy, the done pulse and the {remainder, quotient} result.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   div1;
  logic [WIDTH-1:0]   div2;
  logic               valid;
  logic               flag_unsigned;
  logic               cancel;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output div1, div2, valid, flag_unsigned, cancel,
    input  busy, done, result
  );

  modport slave (
    input  div1, div2, valid, flag_unsigned, cancel,
    output busy, done, result
  );
endinterface

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for the HI/LO unit (DIV / DIVU).
// One quotient bit is produced per cycle on operand magnitudes. Sign correction
// is applied in a final cycle that also registers the result and pulses done.
// result = {remainder, quotient}. It holds until the next completion or reset.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  div_iter_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               step;
  logic               finish;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   dvs_mag;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic               q_neg;
  logic               r_neg;
  logic               div_zero;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  logic               done_r;
  logic [2*WIDTH-1:0] result_r;

  // Magnitude of a two's-complement operand. The most negative value maps to
  // 2^(WIDTH-1), which is still representable as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(
    input logic signed [WIDTH-1:0] v,
    input logic                    is_signed
  );
    logic signed [WIDTH-1:0] neg_v;
    neg_v = -v;
    if (is_signed && v[WIDTH-1]) begin
      return neg_v;
    end
    return v;
  endfunction

  // Conditional two's-complement negation used for the final sign correction.
  function automatic logic [WIDTH-1:0] apply_sign(
    input logic [WIDTH-1:0] v,
    input logic             neg
  );
    logic signed [WIDTH-1:0] sv;
    logic signed [WIDTH-1:0] neg_sv;
    sv     = v;
    neg_sv = -sv;
    return neg ? neg_sv : sv;
  endfunction

  // State register. Reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. Cancel beats valid. FIN always completes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.valid && !bus.cancel) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == LAST_STEP) begin
            state_next = FIN;
          end
        end
      end
      FIN: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Restoring step: shift {rem, quo} left, then trial-subtract the divisor magnitude.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_mag};
    quo_fix = div_zero ? {WIDTH{1'b1}} : apply_sign(quo, q_neg);
    rem_fix = apply_sign(rem, r_neg);
  end

  // Operand latch, iteration registers, result register and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      dvs_mag  <= '0;
      rem      <= '0;
      quo      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= finish;
      if (accept) begin
        dvs_mag  <= magnitude(bus.div2, !bus.flag_unsigned);
        quo      <= magnitude(bus.div1, !bus.flag_unsigned);
        rem      <= '0;
        q_neg    <= !bus.flag_unsigned && (bus.div1[WIDTH-1] ^ bus.div2[WIDTH-1]);
        r_neg    <= !bus.flag_unsigned && bus.div1[WIDTH-1];
        div_zero <= (bus.div2 == '0);
        cnt      <= '0;
      end else if (step) begin
        if (!trial[WIDTH]) begin
          rem <= trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt + CNT_ONE;
      end
      if (finish) begin
        result_r <= {rem_fix, quo_fix};
      end
    end
  end

  assign bus.busy   = (state == CALC) || (state == FIN);
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: expected results go into a queue when an
// operation is started and are popped when done pulses.
module tb_div_iter;

  logic clk;
  logic reset;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res;
  time         t_start;

  // Reference quotient/remainder using 64-bit host arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic fu);
    longint unsigned ua, ub, uq, ur;
    longint          sa, sb, sq, sr;
    logic [63:0]     qv, rv;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (fu) begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      uq = ua / ub;
      ur = ua % ub;
      qv = uq;
      rv = ur;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      sq = sa / sb;
      sr = sa % sb;
      qv = sq;
      rv = sr;
    end
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request; call right after a negedge. Returns at the next negedge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic fu,
                          input bit expect_done);
    bus.div1          = a;
    bus.div2          = b;
    bus.flag_unsigned = fu;
    bus.valid         = 1'b1;
    t_start           = $time;
    if (expect_done) exp_q.push_back(model(a, b, fu));
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  // Wait (bounded) for done, then check latency, result and pulse width.
  task automatic wait_done(input string tag);
    int          n;
    logic [63:0] exp;
    n = 0;
    while (!bus.done && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done_seen"}, {63'd0, bus.done}, 64'd1);
    if (bus.done) begin
      chk({tag, " latency"}, 64'(($time - t_start) / 10), 64'd34);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      last_res = exp;
      chk({tag, " result"}, bus.result, exp);
      @(negedge clk);
      chk({tag, " done_width"}, {63'd0, bus.done}, 64'd0);
    end
  endtask

  // Count done pulses over a window where none may appear.
  task automatic no_done(input string tag, input int cycles);
    int dones;
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk({tag, " no_done"}, 64'(dones), 64'd0);
  endtask

  initial begin
    reset             = 1'b1;
    bus.div1          = '0;
    bus.div2          = '0;
    bus.valid         = 1'b0;
    bus.flag_unsigned = 1'b0;
    bus.cancel        = 1'b0;
    last_res          = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset busy",   {63'd0, bus.busy}, 64'd0);
    chk("reset done",   {63'd0, bus.done}, 64'd0);
    chk("reset result", bus.result, 64'd0);

    start_op(32'd7, 32'd2, 1'b1, 1'b1);
    chk("calc busy", {63'd0, bus.busy}, 64'd1);
    wait_done("u7/2");
    chk("u7/2 const", last_res, {32'd1, 32'd3});

    start_op(-32'sd7, 32'd2, 1'b0, 1'b1);
    wait_done("s-7/2");
    chk("s-7/2 const", last_res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    start_op(32'd7, -32'sd2, 1'b0, 1'b1);
    wait_done("s7/-2");
    chk("s7/-2 const", last_res, {32'd1, 32'hFFFF_FFFD});

    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done("s_ovf");
    chk("s_ovf const", last_res, {32'd0, 32'h8000_0000});
    start_op(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
    wait_done("u_max/1");
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done("u_8/max");
    chk("u_8/max const", last_res, {32'h8000_0000, 32'd0});

    start_op(32'd1234, 32'd0, 1'b1, 1'b1);
    wait_done("u_div0");
    start_op(32'd1234, 32'd0, 1'b0, 1'b1);
    wait_done("s_div0");
    chk("s_div0 const", last_res, {32'd1234, 32'hFFFF_FFFF});
    start_op(-32'sd5, 32'd0, 1'b0, 1'b1);
    wait_done("s_neg_div0");

    // Operands change and valid re-pulses while busy: must be ignored.
    start_op(32'd100, 32'd7, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    bus.div1  = 32'd999;
    bus.div2  = 32'd3;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    wait_done("ignore_valid");

    // Cancel at step 10.
    start_op(32'd5000, 32'd13, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    chk("pre_cancel busy", {63'd0, bus.busy}, 64'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel busy", {63'd0, bus.busy}, 64'd0);
    chk("cancel done", {63'd0, bus.done}, 64'd0);
    no_done("cancel", 40);
    chk("cancel result_kept", bus.result, last_res);
    start_op(32'd5000, 32'd13, 1'b1, 1'b1);
    wait_done("after_cancel");

    // Reset at step 20.
    start_op(-32'sd100000, 32'd77, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy",   {63'd0, bus.busy}, 64'd0);
    chk("midreset done",   {63'd0, bus.done}, 64'd0);
    chk("midreset result", bus.result, 64'd0);
    no_done("midreset", 40);
    start_op(-32'sd519408, 32'd666, 1'b0, 1'b1);
    wait_done("after_reset");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
